mult_datapath: RTL and testbench
================================

# mult_datapath

Iterative shift-add multiplier datapath that sits directly downstream of the multiplier control FSM.
- Captures the X and Y operands from a shared input bus on the control unit's load strobes.
- Flags invalid operand pairs on `error`, runs a radix-2 multiplication when `op_en` pulses, and returns a one-cycle `done` pulse with a registered 2·WIDTH-bit product.

## Interface
- `WIDTH`, default 16: operand width in bits; product is 2·WIDTH bits; WIDTH ≥ 2.
- `clk`  in  1: single clock, all state updates on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `data_in`  in  WIDTH: shared operand bus.
- `load_x`  in  1: capture `data_in` into X at the clock edge.
- `load_y`  in  1: capture `data_in` into Y at the clock edge.
- `op_en`  in  1: single-cycle start strobe.
- `error`  out  1: operand pair invalid (combinational from X/Y registers).
- `done`  out  1: one-cycle pulse when the product is valid.
- `busy`  out  1: multiplication in progress.
- `result`  out  2·WIDTH: product register, held until the next completion.

## Operation
- **Operand registers X, Y**
  - Written on any edge where `load_x`/`load_y` is high, including while busy.
  - If both are high in the same cycle, both registers take `data_in`.
- **`error`**
  - Pure function of the stored X and Y, so it is stable one cycle after `load_y`, ahead of the control unit's VALIDATE state.
  - Under the signed configuration, `error`=1 iff X or Y equals −2^(WIDTH−1).
  - Otherwise `error`=0.
- **FSM states**
  - IDLE: `busy`=0. If `op_en`=1, go to RUN and load the internal copies:
    - multiplicand M = |X|, zero-extended to 2·WIDTH;
    - multiplier Q = |Y|;
    - accumulator A = 0;
    - counter = WIDTH;
    - sign flag S = sign(X) XOR sign(Y) (S=0 when unsigned).
  - RUN: `busy`=1. Each edge performs one iteration:
    - if Q[0] then A += M;
    - M <<= 1; Q >>= 1; counter −= 1.
    - On the edge where counter reaches 0, write `result` = S ? −A_final : A_final (2·WIDTH-bit two's complement) and go to FINISH.
  - FINISH: `done`=1, `busy`=0. Next edge goes to IDLE unconditionally.
- **Internal copies**
  - The in-flight operation uses only M, Q, A, S. Operand loads during RUN do not affect it.
- **Strobe handling**
  - `op_en` in RUN or FINISH is ignored, not queued.
- **Arithmetic**
  - Unsigned product is exact in 2·WIDTH bits, no overflow.
  - Signed product is exact, because −2^(WIDTH−1) operands are excluded by `error`.
  - If `op_en` is issued anyway with an error pair, the result is computed mod 2^(2·WIDTH) with no further checking. The control unit never does this.
- **Zero operands**
  - Still take the full WIDTH iterations; there is no early termination.

## Timing
- **Reset values:** `result`=0, `done`=0, `busy`=0, X=0, Y=0, state IDLE, so `error`=0.
- **Reset mid-operation:** `rst` high aborts immediately (asynchronous). No `done` is produced, and `result` returns to 0.
- **Latency:** `op_en` sampled at edge 0.
  - Iterations occur at edges 1..WIDTH.
  - `result` is valid and `done`=1 during the cycle after edge WIDTH.
  - `busy`=1 for exactly WIDTH cycles.
- **Back-to-back throughput:** the next `op_en` is accepted in the cycle after `done`, giving WIDTH+2 cycles per product.
- **`result` hold:** unchanged from `done` until the next completion or reset.

## Configuration
- **Macro:** `MULT_SIGNED_EN`.
- **Defined:**
  - X and Y are two's complement.
  - Absolute values and the sign flag are used as described in Operation.
  - `error` detects −2^(WIDTH−1) operands.
  - `result` is a signed 2·WIDTH-bit product.
- **Undefined:**
  - Operands are unsigned; S is forced to 0 and no abs/negate logic is built.
  - `error` is tied to 0.

## Test plan
- **Unsigned basic, WIDTH=16:** load X=300, Y=200; `op_en` -> `busy` for 16 cycles, then `done` pulse with `result`=60000; `result` still 60000 ten cycles later.
- **Unsigned max:** X=Y=0xFFFF -> `result`=0xFFFE0001. With X=0 -> `result`=0, latency still 16 cycles.
- **Signed (`MULT_SIGNED_EN`):**
  - X=−7 (0xFFF9), Y=6 -> `result`=0xFFFFFFD6.
  - X=−3, Y=−5 -> `result`=15.
  - Load X=0x8000 -> `error`=1 one cycle after the load; reload X=5 -> `error`=0.
- **Hazards:**
  - Pulse `op_en` again at cycle 5 of RUN -> ignored, single `done` at the original time.
  - Load X=9 during RUN -> in-flight product unchanged.
- **Reset mid-operation:** assert `rst` at iteration 8 -> `busy`, `done` and `result` are 0 immediately, and no `done` follows.
- **Back-to-back:** `op_en` in the cycle after `done` -> accepted, second `done` WIDTH+2 cycles after the first.

Source files
------------

// File: rtl/mult_datapath.sv
// ---------------------------------------------------------------------------
// mult_datapath
//   Radix-2 shift-add multiplier datapath driven by an external control FSM.
//   The X and Y operands are captured from a shared bus on load strobes.
//   op_en starts a WIDTH-iteration multiply. A one-cycle done pulse follows,
//   and the product is held in a register.
//
//   Build option: `MULT_SIGNED_EN
//     defined   : two's complement operands; magnitude/sign datapath built;
//                 error flags a -2^(WIDTH-1) operand
//     undefined : unsigned operands; error tied low
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   data_in    : shared operand bus (WIDTH)
//   load_x/y   : capture data_in into X / Y
//   op_en      : single-cycle start strobe (ignored unless idle)
//   error      : operand pair invalid (combinational from X/Y)
//   done       : one-cycle pulse, result valid
//   busy       : iterations in progress
//   result     : 2*WIDTH product, held until next completion
// ---------------------------------------------------------------------------
module mult_datapath #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               load_x,
  input  logic               load_y,
  input  logic               op_en,
  output logic               error,
  output logic               done,
  output logic               busy,
  output logic [2*WIDTH-1:0] result
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state;
  logic [WIDTH-1:0] x_q, y_q;
  logic [PW-1:0]    m_q, a_q;
  logic [WIDTH-1:0] q_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] x_mag, y_mag;
  logic [PW-1:0]    a_next, prod;

  // One iteration's accumulate; also the final sum on the last edge.
  assign a_next = q_q[0] ? a_q + m_q : a_q;

`ifdef MULT_SIGNED_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic s_q;
  logic sgn;

  assign x_mag = x_q[WIDTH-1] ? (~x_q + 1'b1) : x_q;
  assign y_mag = y_q[WIDTH-1] ? (~y_q + 1'b1) : y_q;
  assign sgn   = x_q[WIDTH-1] ^ y_q[WIDTH-1];
  // The most negative value has no positive magnitude in WIDTH bits.
  assign error = (x_q == MOST_NEG) || (y_q == MOST_NEG);
  assign prod  = s_q ? (~a_next + 1'b1) : a_next;
`else
  assign x_mag = x_q;
  assign y_mag = y_q;
  assign error = 1'b0;
  assign prod  = a_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      x_q    <= '0;
      y_q    <= '0;
      m_q    <= '0;
      a_q    <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
`ifdef MULT_SIGNED_EN
      s_q    <= 1'b0;
`endif
    end else begin
      // Operand capture is independent of the FSM; RUN uses private copies.
      if (load_x) x_q <= data_in;
      if (load_y) y_q <= data_in;

      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (op_en) begin
            m_q   <= {{WIDTH{1'b0}}, x_mag};
            q_q   <= y_mag;
            a_q   <= '0;
            cnt_q <= CW'(WIDTH);
`ifdef MULT_SIGNED_EN
            s_q   <= sgn;
`endif
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_next;
          m_q   <= m_q << 1;
          q_q   <= q_q >> 1;
          cnt_q <= cnt_q - 1'b1;
          // On the last iteration, store the completed sum directly.
          if (cnt_q == CW'(1)) begin
            result <= prod;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= FINISH;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_datapath.sv
module tb_mult_datapath;
  localparam int W  = 16;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_in;
  logic          load_x, load_y, op_en;
  logic          error, done, busy;
  logic [PW-1:0] result;

  int ncmp  = 0;
  int nfail = 0;

  // Operand values the bench believes X/Y hold, and the last product it expects.
  logic [W-1:0]  mx, my;
  logic [PW-1:0] last_res;

  mult_datapath #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load_x(load_x), .load_y(load_y),
    .op_en(op_en), .error(error), .done(done), .busy(busy), .result(result)
  );

  always #5 clk = ~clk;

  // Reference: plain integer multiply in the configured number system.
  function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
`ifdef MULT_SIGNED_EN
    p = longint'($signed(a)) * longint'($signed(b));
`else
    p = longint'({1'b0, a}) * longint'({1'b0, b});
`endif
    return p[PW-1:0];
  endfunction

  function automatic logic ref_err(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SIGNED_EN
    return (a == 16'h8000) || (b == 16'h8000);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load both operands (X then Y); the check happens one cycle after the Y load.
  task automatic load_xy(input logic [W-1:0] a, input logic [W-1:0] b);
    data_in = a; load_x = 1'b1;
    @(negedge clk);
    load_x = 1'b0; data_in = b; load_y = 1'b1;
    @(negedge clk);
    load_y = 1'b0;
    mx = a; my = b;
    chk("error_after_load", error, ref_err(mx, my));
  endtask

  // Run one product. Optionally re-pulse op_en or load X=9 at a given RUN cycle.
  task automatic mult(input string tag, input int op_at, input int ldx_at);
    logic [PW-1:0] exp;
    exp = ref_prod(mx, my);
    op_en = 1'b1;
    @(negedge clk);
    op_en = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_nodone"}, done, 1'b0);
      chk({tag, "_hold"}, result, last_res);
      op_en  = (i == op_at);
      load_x = (i == ldx_at);
      data_in = 16'd9;
      if (i == ldx_at) mx = 16'd9;
      @(negedge clk);
      op_en = 1'b0; load_x = 1'b0;
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_off"}, busy, 1'b0);
    chk({tag, "_result"}, result, exp);
    last_res = exp;
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1; data_in = '0; load_x = 1'b0; load_y = 1'b0; op_en = 1'b0;
    mx = '0; my = '0; last_res = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;
    @(negedge clk);

`ifdef MULT_SIGNED_EN
    load_xy(16'hFFF9, 16'd6);      mult("neg_pos", -1, -1);
    load_xy(16'hFFFD, 16'hFFFB);   mult("neg_neg", -1, -1);
`endif
    // Basic product, then hold check ten cycles later.
    load_xy(16'd300, 16'd200);
    mult("basic", -1, -1);
    repeat (10) @(negedge clk);
    chk("hold_10", result, last_res);

    load_xy(16'hFFFF, 16'hFFFF);   mult("max", -1, -1);
    load_xy(16'd0, 16'd1234);      mult("zero_x", -1, -1);

    // Most-negative detection (error stays low in the unsigned build).
    load_xy(16'h8000, 16'd3);
    load_xy(16'd5, 16'd3);

    // Hazards: re-strobe at RUN cycle 5, X reload mid-run.
    load_xy(16'd1234, 16'd77);     mult("restrobe", 5, -1);
    chk("restrobe_idle", busy, 0);
    load_xy(16'd1000, 16'd33);     mult("ldx_run", -1, 3);
    chk("ldx_took_x", dut.x_q, 16'd9);

    // Back-to-back: second op_en in the cycle after done.
    load_xy(16'd11, 16'd13);
    mult("b2b_a", -1, -1);
    mult("b2b_b", -1, -1);

    // Randomized products.
    for (int k = 0; k < 20; k++) begin
      ra = W'($urandom); rb = W'($urandom);
      while (ref_err(ra, rb)) begin ra = W'($urandom); rb = W'($urandom); end
      load_xy(ra, rb);
      mult("rand", -1, -1);
    end

    // Reset mid-operation at iteration 8.
    load_xy(16'd500, 16'd600);
    op_en = 1'b1;
    @(negedge clk);
    op_en = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      chk("midrst_nodone", done, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
